mealy_pattern_detector: RTL

- Parametrised Mealy sequence detector for a serial bit stream.
- Compares the newest `PAT_LEN` valid input bits against a runtime-loaded pattern, with a per-bit don't-care mask and a selectable overlap mode.
- Counts matches in a saturating counter.
- Generalises the team's fixed 4-state Mealy machines. It sits between a serial front end and a control/status block, and `match` is usable combinationally in the same cycle as the input.

---
 rtl/mealy_pkg.sv | 29 ++
 rtl/mealy_pattern_detector_sat_counter.sv | 52 +++++
 rtl/mealy_pattern_detector.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mealy_pkg.sv
// ---------------------------------------------------------------------------
// mealy_pkg
// Shared definitions for the parametrised Mealy pattern detector.
//   state_t    : three-state controller encoding (2'd3 is unused/illegal)
//   *_MIN/_MAX : legal parameter ranges for PAT_LEN and CNT_W
//   range_ok   : helper used by the elaboration-time parameter check
// ---------------------------------------------------------------------------
package mealy_pkg;

   // Controller states. The spare code 2'd3 is never entered on purpose;
   // the detector treats it as a fault and falls back to S_UNCFG.
   typedef enum logic [1:0] {
      S_UNCFG = 2'd0,
      S_FILL  = 2'd1,
      S_ARMED = 2'd2
   } state_t;

   // Legal parameter ranges.
   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 32;
   localparam int CNT_W_MIN   = 1;
   localparam int CNT_W_MAX   = 32;

   // True when value lies inside [lo, hi].
   function automatic bit range_ok(input int value, input int lo, input int hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/mealy_pattern_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating match counter with a sticky saturation flag.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clr     : clear count and sat (applied before a same-cycle increment)
//   inc     : increment request
//   count   : registered count, holds at all-ones
//   sat     : registered, sticky; set once count reaches all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] base_count;
   logic             base_sat;
   logic [CNT_W-1:0] next_count;

   // Clear is applied first, so a clear and an increment in the same cycle
   // leave the counter at one rather than zero. The increment is suppressed
   // at all-ones so the count never wraps.
   always_comb begin
      base_count = clr ? '0 : count;
      base_sat   = clr ? 1'b0 : sat;
      next_count = base_count;
      if (inc && (base_count != CNT_MAX)) begin
         next_count = base_count + 1'b1;
      end
   end

   // Count register and sticky flag; the flag follows the value being
   // written so it rises in the same cycle the count reaches all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= next_count;
         sat   <= base_sat | (next_count == CNT_MAX);
      end
   end

endmodule

// File: rtl/mealy_pattern_detector.sv
// ---------------------------------------------------------------------------
// mealy_pattern_detector
// Serial-stream Mealy detector: compares the newest PAT_LEN valid bits with
// a runtime-loaded pattern under a don't-care mask, optionally allowing
// overlapping matches, and counts matches in a saturating counter.
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   cfg_load    : strobe; latches pattern/mask/overlap, restarts detection
//   cfg_pattern : pattern, bit PAT_LEN-1 oldest, bit 0 newest
//   cfg_mask    : 1 = compare position, 0 = don't care
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   clr_count   : clears match_count and count_sat
//   in_valid    : qualifies in_bit
//   in_bit      : serial data bit
//   match       : combinational Mealy output, same cycle as the input bit
//   armed       : registered; a match is possible on the next valid bit
//   match_count : registered saturating match count
//   count_sat   : registered sticky saturation flag
// ---------------------------------------------------------------------------
module mealy_pattern_detector
   import mealy_pkg::*;
#(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_load,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic [PAT_LEN-1:0] cfg_mask,
   input  logic               cfg_overlap,
   input  logic               clr_count,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               match,
   output logic               armed,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   // Enough bits to count up to PAT_LEN-1 history bits.
   localparam int FILL_W = $clog2(PAT_LEN);

   // Reject out-of-range parameters at elaboration.
   generate
      if (!range_ok(PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX) ||
          !range_ok(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_params
         $error("mealy_pattern_detector: PAT_LEN or CNT_W outside legal range");
      end
   endgenerate

   state_t             state;
   logic [PAT_LEN-1:0] pattern_q;
   logic [PAT_LEN-1:0] mask_q;
   logic               overlap_q;
   logic [PAT_LEN-2:0] hist;
   logic [FILL_W-1:0]  fill;
   logic               armed_q;

   logic [PAT_LEN-1:0] window;
   logic               hit;

   // The comparison window is the stored history with the current bit
   // appended as the newest position. Its low PAT_LEN-1 bits are also the
   // next history value, so one vector serves both the compare and the shift.
   assign window = {hist, in_bit};
   assign hit    = (((window ^ pattern_q) & mask_q) == '0);

   // Mealy output: a configuration load has priority and drops the bit.
   assign match  = in_valid & ~cfg_load & (state == S_ARMED) & hit;
   assign armed  = armed_q;

   // Controller, history shift register and fill counter. A load restarts
   // detection from an empty history in any state. In S_FILL the history
   // collects PAT_LEN-1 bits before arming; in S_ARMED every valid bit is
   // compared and shifted, and a non-overlapping match throws the history
   // away logically by clearing the fill count so PAT_LEN fresh bits are
   // needed for the next match. armed_q is written alongside every state
   // change so it always mirrors "state is S_ARMED" one register deep.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_UNCFG;
         pattern_q <= '0;
         mask_q    <= '0;
         overlap_q <= 1'b0;
         hist      <= '0;
         fill      <= '0;
         armed_q   <= 1'b0;
      end else if (cfg_load) begin
         state     <= S_FILL;
         pattern_q <= cfg_pattern;
         mask_q    <= cfg_mask;
         overlap_q <= cfg_overlap;
         hist      <= '0;
         fill      <= '0;
         armed_q   <= 1'b0;
      end else begin
         case (state)
            S_UNCFG: begin
               armed_q <= 1'b0;
            end
            S_FILL: begin
               if (in_valid) begin
                  hist <= window[PAT_LEN-2:0];
                  fill <= fill + 1'b1;
                  if (fill == FILL_W'(PAT_LEN - 2)) begin
                     state   <= S_ARMED;
                     armed_q <= 1'b1;
                  end
               end
            end
            S_ARMED: begin
               if (in_valid) begin
                  hist <= window[PAT_LEN-2:0];
                  if (hit && !overlap_q) begin
                     fill    <= '0;
                     state   <= S_FILL;
                     armed_q <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= S_UNCFG;
               hist    <= '0;
               fill    <= '0;
               armed_q <= 1'b0;
            end
         endcase
      end
   end

   // A load clears the counter together with the detector state.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_count | cfg_load),
      .inc     (match),
      .count   (match_count),
      .sat     (count_sat)
   );

endmodule
